// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the display controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int unsigned BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIG0  = 7'b1000000;
  localparam logic [6:0] SEG_DIG1  = 7'b1111001;
  localparam logic [6:0] SEG_DIG2  = 7'b0100100;
  localparam logic [6:0] SEG_DIG3  = 7'b0110000;
  localparam logic [6:0] SEG_DIG4  = 7'b0011001;
  localparam logic [6:0] SEG_DIG5  = 7'b0010010;
  localparam logic [6:0] SEG_DIG6  = 7'b0000010;
  localparam logic [6:0] SEG_DIG7  = 7'b1111000;
  localparam logic [6:0] SEG_DIG8  = 7'b0000000;
  localparam logic [6:0] SEG_DIG9  = 7'b0010000;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = SEG_DIG0;
      4'd1:    s = SEG_DIG1;
      4'd2:    s = SEG_DIG2;
      4'd3:    s = SEG_DIG3;
      4'd4:    s = SEG_DIG4;
      4'd5:    s = SEG_DIG5;
      4'd6:    s = SEG_DIG6;
      4'd7:    s = SEG_DIG7;
      4'd8:    s = SEG_DIG8;
      4'd9:    s = SEG_DIG9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction; 4-bit add, carry out deliberately dropped.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; dash overrides blank, which overrides the digit.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      seg = seg_digit(digit);
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// Sequential binary-to-BCD converter (one bit per clock) plus a multiplexed
// four-digit seven-segment scanner showing the last completed result.
module display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned ScratchW = (BCD_DIGITS + 1) * 4;
  localparam int unsigned DivW     = $clog2(REFRESH_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(REFRESH_DIV - 1);

  state_e              state_q, state_d;
  logic [15:0]         shreg_q, shreg_d;
  logic [ScratchW-1:0] scratch_q, scratch_d, adj;
  logic [3:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [15:0]         pend_val_q, pend_val_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [DivW-1:0]     div_q, div_d;
  logic [1:0]          idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;
  logic [3:0]          digit;
  logic [3:0]          lead_zero;
  logic                blank;

  always_comb begin
    for (int i = 0; i < int'(BCD_DIGITS) + 1; i++) begin
      adj[4*i +: 4] = add3(scratch_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d   = value;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StLatch;
        end
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      StLatch: begin
        bcd_d = scratch_q[15:0];
        ovf_d = |scratch_q[ScratchW-1:16];
        // A strobe arriving now is newer than anything pending.
        if (load || pend_q) begin
          shreg_d   = load ? value : pend_val_q;
          scratch_d = '0;
          cnt_d     = '0;
          pend_d    = 1'b0;
          state_d   = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivMax) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    unique case (idx_q)
      2'd0:    digit = bcd_q[15:12];
      2'd1:    digit = bcd_q[11:8];
      2'd2:    digit = bcd_q[7:4];
      default: digit = bcd_q[3:0];
    endcase

    lead_zero[0] = (bcd_q[15:12] == 4'd0);
    lead_zero[1] = lead_zero[0] && (bcd_q[11:8] == 4'd0);
    lead_zero[2] = lead_zero[1] && (bcd_q[7:4] == 4'd0);
    lead_zero[3] = 1'b0;
    blank = BLANK_LZ && lead_zero[idx_q];
    an_d  = ~(4'b1000 >> idx_q);
  end

  seg7_decode u_seg7_decode (
    .digit (digit),
    .blank (blank),
    .dash  (ovf_q),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      an_q       <= 4'b0111;
      seg_q      <= BLANK_LZ ? SEG_BLANK : SEG_DIG0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl with REFRESH_DIV=4, BLANK_LZ=1: table of conversions
// plus hand-written sequences for pending loads, LATCH-cycle loads and mid-conversion reset.
module tb_display_ctrl;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    logic [15:0] value;
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] segs;  // {thousands, hundreds, tens, ones}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        busy;
  logic [15:0] bcd;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  vec_t vecs[11];

  display_ctrl #(
    .REFRESH_DIV (4),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .busy  (busy),
    .bcd   (bcd),
    .ovf   (ovf),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int idx;
    pulse(v.value);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk($sformatf("busy_cycles[%0d]", v.value), n, 17);
    chk($sformatf("bcd[%0d]", v.value), {16'h0, bcd}, {16'h0, v.bcd});
    chk($sformatf("ovf[%0d]", v.value), {31'h0, ovf}, {31'h0, v.ovf});
    step();
    step();
    for (int s = 0; s < 16; s++) begin
      case (an)
        4'b0111: idx = 0;
        4'b1011: idx = 1;
        4'b1101: idx = 2;
        4'b1110: idx = 3;
        default: idx = -1;
      endcase
      chk($sformatf("scan_an_valid[%0d]", v.value), {31'h0, idx >= 0}, 32'h1);
      if (idx >= 0) begin
        chk($sformatf("scan_seg[%0d] digit %0d", v.value, idx), {25'h0, seg},
            {25'h0, v.segs[(3-idx)*7 +: 7]});
      end
      step();
    end
  endtask

  initial begin
    logic [3:0] prev_an;
    int n;
    int gaps;
    int seen100;

    vecs[0]  = '{16'd1234,  16'h1234, 1'b0, {S1, S2, S3, S4}};
    vecs[1]  = '{16'd7,     16'h0007, 1'b0, {SB, SB, SB, S7}};
    vecs[2]  = '{16'd9999,  16'h9999, 1'b0, {S9, S9, S9, S9}};
    vecs[3]  = '{16'd10000, 16'h0000, 1'b1, {SD, SD, SD, SD}};
    vecs[4]  = '{16'd65535, 16'h5535, 1'b1, {SD, SD, SD, SD}};
    vecs[5]  = '{16'd0,     16'h0000, 1'b0, {SB, SB, SB, S0}};
    vecs[6]  = '{16'd305,   16'h0305, 1'b0, {SB, S3, S0, S5}};
    vecs[7]  = '{16'd1000,  16'h1000, 1'b0, {S1, S0, S0, S0}};
    vecs[8]  = '{16'd80,    16'h0080, 1'b0, {SB, SB, S8, S0}};
    vecs[9]  = '{16'd5678,  16'h5678, 1'b0, {S5, S6, S7, S8}};
    vecs[10] = '{16'd56,    16'h0056, 1'b0, {SB, SB, S5, S6}};

    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    step();
    step();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_bcd", {16'h0, bcd}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_an", {28'h0, an}, 32'h7);
    chk("rst_seg", {25'h0, seg}, {25'h0, SB});
    rst = 1'b0;

    // Each digit stays enabled for REFRESH_DIV cycles.
    for (int r = 0; r < 2; r++) begin
      prev_an = an;
      n = 0;
      while (an == prev_an && n < 20) begin
        step();
        n++;
      end
      prev_an = an;
      n = 0;
      while (an == prev_an && n < 20) begin
        step();
        n++;
      end
      chk("digit_dwell", n, 4);
    end

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Loads while busy: 100 is overwritten by 305, no busy gap.
    pulse(16'd42);
    chk("pend_busy_start", {31'h0, busy}, 32'h1);
    gaps = 0;
    seen100 = 0;
    for (int k = 1; k <= 34; k++) begin
      load  = (k == 3) || (k == 6);
      value = (k == 3) ? 16'd100 : 16'd305;
      step();
      load = 1'b0;
      if (k <= 33 && !busy) gaps++;
      if (bcd == 16'h0100) seen100 = 1;
      if (k == 17) chk("pend_first_result", {16'h0, bcd}, 32'h0042);
    end
    chk("pend_no_gap", gaps, 0);
    chk("pend_second_result", {16'h0, bcd}, 32'h0305);
    chk("pend_busy_end", {31'h0, busy}, 32'h0);
    chk("pend_100_never_latched", seen100, 0);

    // Load strobe coincident with LATCH.
    pulse(16'd9);
    gaps = 0;
    for (int k = 1; k <= 34; k++) begin
      load  = (k == 17);
      value = 16'd1000;
      step();
      load = 1'b0;
      if (k <= 33 && !busy) gaps++;
      if (k == 17) chk("latch_load_first", {16'h0, bcd}, 32'h0009);
    end
    chk("latch_load_no_gap", gaps, 0);
    chk("latch_load_second", {16'h0, bcd}, 32'h1000);
    chk("latch_load_busy_end", {31'h0, busy}, 32'h0);

    // Reset at SHIFT cycle 9 with a pending load queued.
    pulse(16'd8888);
    for (int k = 1; k <= 8; k++) begin
      load  = (k == 3);
      value = 16'd777;
      step();
      load = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bcd", {16'h0, bcd}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_an", {28'h0, an}, 32'h7);
    chk("midrst_ovf", {31'h0, ovf}, 32'h0);
    n = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (busy) n++;
    end
    chk("midrst_pending_dropped", n, 0);
    chk("midrst_bcd_held", {16'h0, bcd}, 32'h0);
    run_vec(vecs[10]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Sequential display controller for the calculator's output port. It converts the 16-bit binary value written to the output register into four BCD digits with an iterative shift-and-add-3 engine, one bit per clock. It then drives the four-digit seven-segment display by time-multiplexing the digits. It sits between the memory-mapped output register and the board display, and replaces the combinational binary-to-BCD-plus-scanner path.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; minimum 2.
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows all four digits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  one-cycle strobe, asserted with the output-register write enable.
- value  in  16  unsigned binary value to display; sampled when load=1.
- busy  out  1  conversion in progress.
- bcd  out  16  latched digits {thousands, hundreds, tens, ones}.
- ovf  out  1  latched value exceeds 9999.
- seg  out  7  segment drive, active-low; seg[6:0] = {g,f,e,d,c,b,a}.
- an  out  4  digit enables, active-low; an[3] = thousands, an[0] = ones.

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE with load=1:
  - capture value into a 16-bit shift register;
  - clear the 20-bit BCD scratch (five digits);
  - set bit count to 0;
  - go to SHIFT.
- SHIFT, each cycle:
  - add 3 to every scratch digit that is ≥ 5;
  - shift {scratch, shreg} left by 1.
  - After 16 cycles (count 15 → wrap), go to LATCH.
- LATCH:
  - bcd ← scratch[15:0];
  - ovf ← (scratch[19:16] ≠ 0).
  - If a load is pending, capture the pending value and go to SHIFT; otherwise go to IDLE.
- Load while busy:
  - set the pending flag and store value in a pending register;
  - later loads overwrite it (last write wins);
  - the current conversion is never aborted.
- Load in the same cycle as LATCH is treated as pending and starts the next conversion immediately.
- bcd and ovf change only in LATCH. The display always shows the last completed result.
- Scanner:
  - A divider counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - Index 0 is thousands, index 3 is ones.
  - The scanner runs continuously and independently of the FSM.
- Digit output:
  - an has exactly one bit low: the bit for the selected digit.
  - If ovf=1, every digit shows '-' (g only; seg = 7'b0111111).
  - Otherwise the selected digit is decoded 0-9.
  - With BLANK_LZ=1, a digit is blanked (seg = 7'b1111111) when it and every more-significant digit are 0. The ones digit is never blanked.

## Timing
- Reset values, applied on the first clk edge with rst=1:
  - FSM in IDLE; busy=0, bcd=0, ovf=0; pending cleared;
  - divider=0, digit index=0, an=4'b0111.
  - seg=7'b1111111 with BLANK_LZ=1; 7'b1000000 ('0') otherwise.
- rst asserted mid-conversion discards both the conversion and any pending value. bcd reverts to 0.
- Latency, load sampled at edge k:
  - busy=1 after edge k through edge k+17;
  - bcd and ovf are updated at edge k+17;
  - busy=0 after edge k+17 if nothing is pending;
  - total busy window 17 cycles (16 SHIFT + 1 LATCH).
- Back-to-back conversion with a pending load: busy stays high continuously, and each further conversion adds 17 cycles.
- seg/an are registered. They update one cycle after the divider wraps, and change together so digits never flash.
- Width rules:
  - scratch is 20 bits so 65535 → 6,5,5,3,5 converts without loss;
  - the add-3 is a 4-bit add with no carry out;
  - divider width is $clog2(REFRESH_DIV).

## Structure
- Shared package display_pkg:
  - FSM state enum;
  - seven-segment constants SEG_BLANK, SEG_DASH and the digit patterns 0-9;
  - BCD_DIGITS=4.
- One sub-module, seg7_decode: combinational 4-bit digit + blank + dash → 7-bit seg, using the package constants.
- The FSM, conversion datapath and scanner stay in display_ctrl.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset, then load value=1234: busy high for 17 cycles, bcd=16'h1234, ovf=0. The scan shows 1,2,3,4 on an=0111,1011,1101,1110, 4 cycles per digit.
- Load 7 with BLANK_LZ=1: bcd=16'h0007, only an[0] shows seg=7'b1111000, the other digit slots are blank. Load 9999: bcd=16'h9999, all digits lit.
- Load 10000, then 65535: ovf=1 each time, bcd=16'h0000 then 16'h5535, all four digits show 7'b0111111.
- Load 42, then load 100 and 305 while busy: the first result is 0042, busy stays high without a gap, and the second result is 0305. The value 100 is never latched.
- Load 8888 and assert rst at SHIFT cycle 9: bcd=0, busy=0, an=0111 on the next cycle. A subsequent load 56 gives bcd=16'h0056.
- Load strobe in the same cycle as LATCH: the next conversion starts the following cycle, and busy never drops.
